router_link_profiler: RTL

- Parametrised successor to the single-counter mesh router profiler. Attaches beside bsg_mesh_router and observes per-output request and grant matrices.
- Keeps four saturating per-output-direction event counters: idle, utilized, stalled, and optionally arbitrated.
- On a manual or periodic trigger, snapshots all counters and streams them out as a valid/ready record stream. This lets the bench logger, or an on-chip collector, drain the stats without reaching into the block hierarchy.

---
 rtl/router_link_prof_pkg.sv | 46 ++++
 rtl/router_link_prof_ctr_bank.sv | 61 ++++++
 rtl/router_link_profiler.sv | 124 ++++++++++++
 3 files changed

// File: rtl/router_link_prof_pkg.sv
// Shared types for the router link profiler: record kinds, readout states, per-direction stat struct.
// ROUTER_LINK_PROF_ARB_CTR_EN adds the arbitrated counter to every direction.
`ifdef ROUTER_LINK_PROF_ARB_CTR_EN
`define ROUTER_LINK_PROF_STAT_S(w) \
   typedef struct packed { \
      logic [(w)-1:0] idle; \
      logic [(w)-1:0] util; \
      logic [(w)-1:0] stall; \
      logic [(w)-1:0] arb; \
   } stat_s
`else
`define ROUTER_LINK_PROF_STAT_S(w) \
   typedef struct packed { \
      logic [(w)-1:0] idle; \
      logic [(w)-1:0] util; \
      logic [(w)-1:0] stall; \
   } stat_s
`endif

package router_link_prof_pkg;

   typedef enum logic [1:0] {
      KIND_IDLE  = 2'd0,
      KIND_UTIL  = 2'd1,
      KIND_STALL = 2'd2,
      KIND_ARB   = 2'd3
   } stat_kind_e;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_DRAIN = 1'b1
   } rd_state_e;

`ifdef ROUTER_LINK_PROF_ARB_CTR_EN
   localparam int kinds_lp = 4;
   localparam stat_kind_e last_kind_lp = KIND_ARB;
`else
   localparam int kinds_lp = 3;
   localparam stat_kind_e last_kind_lp = KIND_STALL;
`endif

   function automatic int safe_clog2(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/router_link_prof_ctr_bank.sv
// One output direction's saturating event counters plus their snapshot copy.
// ROUTER_LINK_PROF_ARB_CTR_EN adds the arbitrated (contended grant) counter.
module router_link_prof_ctr_bank
   import router_link_prof_pkg::*;
  #(parameter int dirs_p      = 5,
    parameter int ctr_width_p = 32)
   (input  logic                            clk_i,
    input  logic                            reset_n_i,
    input  logic [dirs_p-1:0]               req,
    input  logic [dirs_p-1:0]               yumi,
    input  logic                            count_en,
    input  logic                            clear,
    input  logic                            snap,
    output logic [kinds_lp*ctr_width_p-1:0] snap_vals);

   `ROUTER_LINK_PROF_STAT_S(ctr_width_p);
   typedef logic [ctr_width_p-1:0] ctr_t;

   function automatic ctr_t sat_inc(input ctr_t v, input logic inc);
      return (inc && (v != '1)) ? v + ctr_t'(1) : v;
   endfunction

   stat_s live_r, live_n, snap_r;
   logic  req_any, grant;

   assign req_any = |req;
   assign grant   = |(req & yumi);

`ifdef ROUTER_LINK_PROF_ARB_CTR_EN
   logic contended;
   assign contended = $countones(req) > 1;
`endif

   always_comb begin
      live_n = live_r;
      if (clear) begin
         live_n = '0;
      end else if (count_en) begin
         live_n.idle  = sat_inc(live_r.idle,  !req_any);
         live_n.util  = sat_inc(live_r.util,  grant);
         live_n.stall = sat_inc(live_r.stall, req_any && !grant);
`ifdef ROUTER_LINK_PROF_ARB_CTR_EN
         live_n.arb   = sat_inc(live_r.arb,   grant && contended);
`endif
      end
   end

   // Snapshot takes this cycle's pre-increment, pre-clear live values
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         live_r <= '0;
         snap_r <= '0;
      end else begin
         live_r <= live_n;
         if (snap) snap_r <= live_r;
      end
   end

   assign snap_vals = snap_r;

endmodule

// File: rtl/router_link_profiler.sv
// Per-output-direction link profiler beside bsg_mesh_router; streams counter snapshots as records.
// ROUTER_LINK_PROF_ARB_CTR_EN enables the arbitrated counter and its fourth record per direction.
module router_link_profiler
   import router_link_prof_pkg::*;
  #(parameter  int dirs_p        = 5,
    parameter  int ctr_width_p   = 32,
    parameter  int period_p      = 250,
    parameter  int periodic_en_p = 0,
    localparam int dir_width_lp  = safe_clog2(dirs_p))
   (input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       en_i,
    input  logic                       arm_i,
    input  logic [dirs_p*dirs_p-1:0]   req_i,
    input  logic [dirs_p*dirs_p-1:0]   yumi_i,
    input  logic                       snapshot_v_i,
    input  logic                       clear_i,
    output logic                       stat_v_o,
    input  logic                       stat_ready_i,
    output logic [dir_width_lp-1:0]    stat_dir_o,
    output logic [1:0]                 stat_kind_o,
    output logic [ctr_width_p-1:0]     stat_value_o,
    output logic                       stat_last_o,
    output logic                       busy_o,
    output logic                       overrun_o);

   `ROUTER_LINK_PROF_STAT_S(ctr_width_p);
   localparam int period_w_lp = safe_clog2(period_p);

   rd_state_e               state_r, state_n;
   logic                    armed_r, overrun_r, count_en;
   logic                    periodic_trig, trig, snap_take, hs, last_rec;
   logic [period_w_lp-1:0]  period_r;
   logic [dir_width_lp-1:0] dir_r;
   stat_kind_e              kind_r;
   stat_s                   snap [dirs_p];
   stat_s                   sel;

   assign count_en      = armed_r & en_i;
   assign periodic_trig = (periodic_en_p != 0) && count_en &&
                          (period_r == period_w_lp'(period_p - 1));
   assign trig          = snapshot_v_i | periodic_trig;
   assign snap_take     = (state_r == ST_IDLE) && trig;
   assign hs            = stat_v_o & stat_ready_i;
   assign last_rec      = (dir_r == dir_width_lp'(dirs_p - 1)) && (kind_r == last_kind_lp);

   for (genvar d = 0; d < dirs_p; d++) begin : g_dir
      router_link_prof_ctr_bank #(
         .dirs_p      (dirs_p),
         .ctr_width_p (ctr_width_p)
      ) u_bank (
         .clk_i     (clk_i),
         .reset_n_i (reset_n_i),
         .req       (req_i[d*dirs_p +: dirs_p]),
         .yumi      (yumi_i[d*dirs_p +: dirs_p]),
         .count_en  (count_en),
         .clear     (clear_i),
         .snap      (snap_take),
         .snap_vals (snap[d])
      );
   end

   always_comb begin
      state_n = state_r;
      case (state_r)
         ST_IDLE:  if (trig) state_n = ST_DRAIN;
         ST_DRAIN: if (hs && last_rec) state_n = ST_IDLE;
         default:  state_n = ST_IDLE;
      endcase
   end

   // Period counter stays at zero when periodic snapshots are disabled
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_r   <= ST_IDLE;
         armed_r   <= 1'b0;
         overrun_r <= 1'b0;
         period_r  <= '0;
         dir_r     <= '0;
         kind_r    <= KIND_IDLE;
      end else begin
         state_r <= state_n;
         if (arm_i) armed_r <= 1'b1;
         if ((state_r == ST_DRAIN) && trig) overrun_r <= 1'b1;
         if ((periodic_en_p != 0) && count_en)
            period_r <= periodic_trig ? '0 : period_r + period_w_lp'(1);
         if (snap_take) begin
            dir_r  <= '0;
            kind_r <= KIND_IDLE;
         end else if (hs) begin
            if (kind_r == last_kind_lp) begin
               kind_r <= KIND_IDLE;
               dir_r  <= last_rec ? '0 : dir_r + dir_width_lp'(1);
            end else begin
               kind_r <= stat_kind_e'(kind_r + 2'd1);
            end
         end
      end
   end

   always_comb begin
      sel          = '0;
      stat_value_o = '0;
      for (int d = 0; d < dirs_p; d++)
         if (dir_r == dir_width_lp'(d)) sel = snap[d];
      case (kind_r)
         KIND_IDLE:  stat_value_o = sel.idle;
         KIND_UTIL:  stat_value_o = sel.util;
         KIND_STALL: stat_value_o = sel.stall;
`ifdef ROUTER_LINK_PROF_ARB_CTR_EN
         KIND_ARB:   stat_value_o = sel.arb;
`endif
         default:    stat_value_o = '0;
      endcase
   end

   assign stat_v_o    = (state_r == ST_DRAIN);
   assign busy_o      = stat_v_o;
   assign stat_dir_o  = dir_r;
   assign stat_kind_o = kind_r;
   assign stat_last_o = stat_v_o & last_rec;
   assign overrun_o   = overrun_r;

endmodule
